// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and the byte-strobe merge helper for the register slave.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    // Sized for the widest supported bus; callers zero-extend and truncate.
    function automatic logic [MAX_DATA_W-1:0] apply_wstrb(
        input logic [MAX_DATA_W-1:0] old_data,
        input logic [MAX_DATA_W-1:0] new_data,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] merged;
        for (int i = 0; i < MAX_STRB_W; i++) begin
            merged[i*8 +: 8] = strb[i] ? new_data[i*8 +: 8] : old_data[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi_lite_addr_check.sv
// Combinational address decode: register index plus OKAY/SLVERR/DECERR verdict.
// Macro AXI_LITE_REG_SLAVE_PROT_CHECK_EN enables the non-secure access check.
module axi_lite_addr_check
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_WIDTH  = 32,
    parameter int                DATA_WIDTH  = 32,
    parameter int                N_REGS      = 16,
    parameter logic [N_REGS-1:0] RO_MASK     = '0,
    parameter logic [N_REGS-1:0] SECURE_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [2:0]                prot,
    input  logic                      is_write,
    output logic [$clog2(N_REGS)-1:0] idx,
    output resp_t                     resp
);
    localparam int IDX_W  = $clog2(N_REGS);
    localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int TOP    = BYTE_W + IDX_W;

    logic [ADDR_WIDTH-1:0] upper;

    assign idx   = addr[TOP-1:BYTE_W];
    assign upper = addr >> TOP;

    // DECERR outranks SLVERR, so the decode test comes first.
    always_comb begin
        resp = OKAY;
        if (|upper) begin
            resp = DECERR;
        end else if (is_write && RO_MASK[idx]) begin
            resp = SLVERR;
        end
`ifdef AXI_LITE_REG_SLAVE_PROT_CHECK_EN
        else if (prot[1] && SECURE_MASK[idx]) begin
            resp = SLVERR;
        end
`endif
    end

`ifdef AXI_LITE_REG_SLAVE_PROT_CHECK_EN
    logic unused_prot;
    assign unused_prot = ^{prot[2], prot[0]};
`else
    logic unused_prot;
    assign unused_prot = ^prot;
`endif

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank slave with independent write and read FSMs.
// Macro AXI_LITE_REG_SLAVE_PROT_CHECK_EN enables secure-register protection checks.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    N_REGS      = 16,
    parameter logic [N_REGS-1:0]     RO_MASK     = '0,
    parameter logic [N_REGS-1:0]     SECURE_MASK = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [ADDR_WIDTH-1:0]        s_awaddr_i,
    input  logic [2:0]                   s_awprot_i,
    input  logic                         s_awvalid_i,
    output logic                         s_awready_o,
    input  logic [DATA_WIDTH-1:0]        s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]      s_wstrb_i,
    input  logic                         s_wvalid_i,
    output logic                         s_wready_o,
    output logic [1:0]                   s_bresp_o,
    output logic                         s_bvalid_o,
    input  logic                         s_bready_i,
    input  logic [ADDR_WIDTH-1:0]        s_araddr_i,
    input  logic [2:0]                   s_arprot_i,
    input  logic                         s_arvalid_i,
    output logic                         s_arready_o,
    output logic [DATA_WIDTH-1:0]        s_rdata_o,
    output logic [1:0]                   s_rresp_o,
    output logic                         s_rvalid_o,
    input  logic                         s_rready_i,
    input  logic [N_REGS*DATA_WIDTH-1:0] hw_rdata_i,
    output logic [N_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [N_REGS-1:0]            wr_pulse_o
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(N_REGS);

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic [DATA_WIDTH-1:0] regs [N_REGS];

    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [2:0]            aw_prot_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [2:0]            wr_prot;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    resp_t                 wr_resp, rd_resp;
    logic [DATA_WIDTH-1:0] rd_value;

    assign aw_hs = s_awvalid_i & s_awready_o;
    assign w_hs  = s_wvalid_i & s_wready_o;
    assign ar_hs = s_arvalid_i & s_arready_o;

    // Whichever half arrived earlier comes from its latch, the other straight off the bus.
    assign wr_addr = (wr_state == W_HAVE_AW) ? aw_addr_q : s_awaddr_i;
    assign wr_prot = (wr_state == W_HAVE_AW) ? aw_prot_q : s_awprot_i;
    assign wr_data = (wr_state == W_HAVE_W) ? w_data_q : s_wdata_i;
    assign wr_strb = (wr_state == W_HAVE_W) ? w_strb_q : s_wstrb_i;
    assign commit  = (aw_hs | (wr_state == W_HAVE_AW)) & (w_hs | (wr_state == W_HAVE_W));

    axi_lite_addr_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .N_REGS     (N_REGS),
        .RO_MASK    (RO_MASK),
        .SECURE_MASK(SECURE_MASK)
    ) u_wr_check (
        .addr    (wr_addr),
        .prot    (wr_prot),
        .is_write(1'b1),
        .idx     (wr_idx),
        .resp    (wr_resp)
    );

    axi_lite_addr_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .N_REGS     (N_REGS),
        .RO_MASK    (RO_MASK),
        .SECURE_MASK(SECURE_MASK)
    ) u_rd_check (
        .addr    (s_araddr_i),
        .prot    (s_arprot_i),
        .is_write(1'b0),
        .idx     (rd_idx),
        .resp    (rd_resp)
    );

    always_ff @(posedge aclk) begin
        if (aw_hs) begin
            aw_addr_q <= s_awaddr_i;
            aw_prot_q <= s_awprot_i;
        end
        if (w_hs) begin
            w_data_q <= s_wdata_i;
            w_strb_q <= s_wstrb_i;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state    <= W_IDLE;
            s_awready_o <= 1'b1;
            s_wready_o  <= 1'b1;
            s_bvalid_o  <= 1'b0;
            s_bresp_o   <= OKAY;
            wr_pulse_o  <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (commit) begin
                wr_state    <= W_RESP;
                s_awready_o <= 1'b0;
                s_wready_o  <= 1'b0;
                s_bvalid_o  <= 1'b1;
                s_bresp_o   <= wr_resp;
                if (wr_resp == OKAY) begin
                    wr_pulse_o <= N_REGS'(1) << wr_idx;
                end
            end else begin
                case (wr_state)
                    W_IDLE: begin
                        if (aw_hs) begin
                            wr_state    <= W_HAVE_AW;
                            s_awready_o <= 1'b0;
                        end else if (w_hs) begin
                            wr_state   <= W_HAVE_W;
                            s_wready_o <= 1'b0;
                        end
                    end
                    W_RESP: begin
                        if (s_bready_i) begin
                            wr_state    <= W_IDLE;
                            s_awready_o <= 1'b1;
                            s_wready_o  <= 1'b1;
                            s_bvalid_o  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (commit && (wr_resp == OKAY)) begin
            regs[wr_idx] <= DATA_WIDTH'(apply_wstrb(MAX_DATA_W'(regs[wr_idx]),
                                                    MAX_DATA_W'(wr_data),
                                                    MAX_STRB_W'(wr_strb)));
        end
    end

    // Non-blocking update of regs means a same-edge write is not yet visible here.
    assign rd_value = RO_MASK[rd_idx] ? hw_rdata_i[rd_idx*DATA_WIDTH +: DATA_WIDTH] : regs[rd_idx];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state    <= R_IDLE;
            s_arready_o <= 1'b1;
            s_rvalid_o  <= 1'b0;
            s_rresp_o   <= OKAY;
            s_rdata_o   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state    <= R_RESP;
                        s_arready_o <= 1'b0;
                        s_rvalid_o  <= 1'b1;
                        s_rresp_o   <= rd_resp;
                        s_rdata_o   <= (rd_resp == OKAY) ? rd_value : '0;
                    end
                end
                R_RESP: begin
                    if (s_rready_i) begin
                        rd_state    <= R_IDLE;
                        s_arready_o <= 1'b1;
                        s_rvalid_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg_out
        assign reg_o[i*DATA_WIDTH +: DATA_WIDTH] =
            RO_MASK[i] ? hw_rdata_i[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Scoreboard bench for axi_lite_reg_slave: directed cases, randomized traffic, async reset.
module tb_axi_lite_reg_slave;
    localparam int          DW = 32;
    localparam int          AW = 32;
    localparam int          NR = 16;
    localparam logic [15:0] RO = 16'h0008;
    localparam logic [15:0] SEC = 16'h0001;
    localparam logic [31:0] RV = 32'h1111_2222;

    logic           aclk, aresetn;
    logic [AW-1:0]  awaddr, araddr;
    logic [2:0]     awprot, arprot;
    logic           awvalid, wvalid, bready, arvalid, rready;
    logic           awready, wready, bvalid, arready, rvalid;
    logic [DW-1:0]  wdata, rdata;
    logic [3:0]     wstrb;
    logic [1:0]     bresp, rresp;
    logic [NR*DW-1:0] hw, reg_out;
    logic [NR-1:0]  wr_pulse;

    typedef struct packed { logic [1:0] resp; logic [15:0] pulse; } b_exp_t;
    typedef struct packed { logic [1:0] resp; logic [31:0] data; } r_exp_t;
    b_exp_t bq[$];
    r_exp_t rq[$];
    logic [31:0] model [NR];
    int checks = 0;
    int failures = 0;
    bit b_first = 1;
    bit r_first = 1;

    axi_lite_reg_slave #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REGS(NR),
        .RO_MASK(RO), .SECURE_MASK(SEC), .RESET_VALUE(RV)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr_i(awaddr), .s_awprot_i(awprot), .s_awvalid_i(awvalid), .s_awready_o(awready),
        .s_wdata_i(wdata), .s_wstrb_i(wstrb), .s_wvalid_i(wvalid), .s_wready_o(wready),
        .s_bresp_o(bresp), .s_bvalid_o(bvalid), .s_bready_i(bready),
        .s_araddr_i(araddr), .s_arprot_i(arprot), .s_arvalid_i(arvalid), .s_arready_o(arready),
        .s_rdata_o(rdata), .s_rresp_o(rresp), .s_rvalid_o(rvalid), .s_rready_i(rready),
        .hw_rdata_i(hw), .reg_o(reg_out), .wr_pulse_o(wr_pulse)
    );

    initial begin
        aclk = 0;
        forever #5 aclk = ~aclk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules: index from addr[5:2], anything above bit 5 is a decode error.
    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [2:0] prot, input bit is_write);
        int idx;
        idx = int'(addr[5:2]);
        if (addr[31:6] != 0) return 2'b11;
        if (is_write && RO[idx]) return 2'b10;
`ifdef AXI_LITE_REG_SLAVE_PROT_CHECK_EN
        if (prot[1] && SEC[idx]) return 2'b10;
`endif
        return 2'b00;
    endfunction

    task automatic expect_write(input logic [31:0] addr, input logic [2:0] prot,
                                input logic [31:0] data, input logic [3:0] strb);
        b_exp_t e;
        int idx;
        idx = int'(addr[5:2]);
        e.resp = exp_resp(addr, prot, 1'b1);
        e.pulse = '0;
        if (e.resp == 2'b00) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            e.pulse = 16'(1) << idx;
        end
        bq.push_back(e);
    endtask

    task automatic expect_read(input logic [31:0] addr, input logic [2:0] prot);
        r_exp_t e;
        int idx;
        idx = int'(addr[5:2]);
        e.resp = exp_resp(addr, prot, 1'b0);
        if (e.resp != 2'b00) e.data = '0;
        else if (RO[idx]) e.data = hw[idx*32 +: 32];
        else e.data = model[idx];
        rq.push_back(e);
    endtask

    task automatic drive_aw(input logic [31:0] addr, input logic [2:0] prot, input int dly, input bit other_later);
        bit done = 0;
        repeat (dly) @(posedge aclk);
        #1; awaddr = addr; awprot = prot; awvalid = 1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(posedge aclk);
            if (awready) done = 1;
        end
        #1; awvalid = 0;
        if (!done) check("aw_timeout", 0, 1);
        else if (other_later) check("awready_hold", awready, 0);
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly, input bit other_later);
        bit done = 0;
        repeat (dly) @(posedge aclk);
        #1; wdata = data; wstrb = strb; wvalid = 1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(posedge aclk);
            if (wready) done = 1;
        end
        #1; wvalid = 0;
        if (!done) check("w_timeout", 0, 1);
        else if (other_later) check("wready_hold", wready, 0);
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                               input logic [3:0] strb, input int awd, input int wd, input int bd);
        bit done = 0;
        fork
            drive_aw(addr, prot, awd, wd > awd);
            drive_w(data, strb, wd, awd > wd);
        join
        check("b_latency", bvalid, 1);
        for (int n = 0; n < bd; n++) begin
            @(posedge aclk); #1;
            check("stall_ready", {awready, wready}, 2'b00);
        end
        bready = 1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(posedge aclk);
            if (bvalid) done = 1;
        end
        #1; bready = 0;
        if (!done) check("b_timeout", 0, 1);
    endtask

    task automatic drive_read(input logic [31:0] addr, input logic [2:0] prot, input int rd);
        bit done = 0;
        #1; araddr = addr; arprot = prot; arvalid = 1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(posedge aclk);
            if (arready) done = 1;
        end
        #1; arvalid = 0;
        if (!done) check("ar_timeout", 0, 1);
        check("r_latency", rvalid, 1);
        repeat (rd) @(posedge aclk);
        #1; rready = 1;
        done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(posedge aclk);
            if (rvalid) done = 1;
        end
        #1; rready = 0;
        if (!done) check("r_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                            input logic [3:0] strb, input int awd, input int wd, input int bd);
        expect_write(addr, prot, data, strb);
        drive_write(addr, prot, data, strb, awd, wd, bd);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] prot, input int rd);
        expect_read(addr, prot);
        drive_read(addr, prot, rd);
    endtask

    task automatic do_collide(input logic [31:0] addr, input logic [31:0] data, input int bd, input int rd);
        expect_read(addr, 3'b000);
        expect_write(addr, 3'b000, data, 4'hF);
        fork
            drive_write(addr, 3'b000, data, 4'hF, 0, 0, bd);
            drive_read(addr, 3'b000, rd);
        join
    endtask

    // Monitor: compares every presented response against the front of its queue.
    always @(negedge aclk) begin
        if (!aresetn) begin
            b_first = 1;
            r_first = 1;
        end else begin
            if (bvalid) begin
                if (bq.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    check("bresp", bresp, bq[0].resp);
                    if (b_first) check("wr_pulse", wr_pulse, bq[0].pulse);
                    else check("wr_pulse_idle", wr_pulse, 0);
                    if (bready) void'(bq.pop_front());
                end
            end else check("wr_pulse_idle", wr_pulse, 0);
            b_first = !bvalid || bready;
            if (rvalid) begin
                if (rq.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    check("rresp", rresp, rq[0].resp);
                    check("rdata", rdata, rq[0].data);
                    if (rready) void'(rq.pop_front());
                end
            end
            r_first = !rvalid || rready;
        end
    end

    initial begin
        int op, idx, awd, wd, bd, rd;
        logic [31:0] addr;
        aresetn = 0;
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        for (int i = 0; i < NR; i++) begin
            hw[i*32 +: 32] = 32'hC0DE_0000 + i;
            model[i] = RV;
        end
        repeat (2) @(posedge aclk);
        #1;
        check("rst_ready", {awready, wready, arready}, 3'b111);
        check("rst_valid", {bvalid, rvalid}, 2'b00);
        check("rst_resp", {bresp, rresp}, 4'h0);
        check("rst_rdata", rdata, 0);
        check("rst_pulse", wr_pulse, 0);
        check("rst_reg0", reg_out[31:0], RV);
        aresetn = 1;
        @(posedge aclk); #1;

        do_write(32'h08, 3'b000, 32'hA5A5_1234, 4'hF, 0, 0, 0);
        do_read(32'h08, 3'b000, 0);
        do_write(32'h04, 3'b000, 32'h0000_00FF, 4'h1, 3, 0, 0);
        do_read(32'h04, 3'b000, 0);
        do_write(32'h40, 3'b000, 32'h1234_5678, 4'hF, 0, 0, 0);
        do_read(32'h40, 3'b000, 0);
        do_write(32'h0C, 3'b000, 32'hFFFF_FFFF, 4'hF, 0, 1, 0);
        do_read(32'h0C, 3'b000, 0);
        do_write(32'h1C, 3'b000, 32'h7777_0001, 4'h6, 1, 0, 5);
        do_read(32'h1C, 3'b000, 5);
        do_write(32'h14, 3'b000, 32'h5555_AAAA, 4'hF, 0, 0, 0);
        do_collide(32'h14, 32'h0BAD_F00D, 1, 2);
        do_read(32'h14, 3'b000, 0);
        do_write(32'h00, 3'b010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(32'h00, 3'b010, 0);
        do_write(32'h00, 3'b000, 32'h0102_0304, 4'hF, 0, 0, 0);
        do_read(32'h00, 3'b000, 0);
        do_write(32'h15, 3'b000, 32'h00CC_0000, 4'h4, 0, 2, 0);
        do_read(32'h16, 3'b000, 0);

        // Async reset with an AW latched and a read response pending
        #1; awaddr = 32'h10; awprot = 0; awvalid = 1;
        @(posedge aclk); #1; awvalid = 0;
        check("have_aw_ready", awready, 0);
        expect_read(32'h08, 3'b000);
        araddr = 32'h08; arprot = 0; arvalid = 1;
        @(posedge aclk); #1; arvalid = 0;
        check("rvalid_pending", rvalid, 1);
        #2; aresetn = 0; #1;
        check("rst_mid_valid", {bvalid, rvalid}, 2'b00);
        check("rst_mid_ready", {awready, wready, arready}, 3'b111);
        bq.delete();
        rq.delete();
        for (int i = 0; i < NR; i++) model[i] = RV;
        @(posedge aclk); #1; aresetn = 1;
        @(posedge aclk); #1;
        check("post_rst_ready", {awready, wready, arready}, 3'b111);
        do_write(32'h20, 3'b000, 32'h0000_4400, 4'h2, 2, 0, 0);
        for (int i = 0; i < NR; i++) do_read(32'(i * 4), 3'b000, 0);

        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 3);
            idx = $urandom_range(0, 15);
            addr = 32'(idx * 4) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h40 << $urandom_range(0, 25));
            awd = $urandom_range(0, 3);
            wd = $urandom_range(0, 3);
            bd = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) hw[3*32 +: 32] = $urandom();
            case (op)
                0, 1: do_write(addr, 3'($urandom_range(0, 7)), $urandom(), 4'($urandom_range(0, 15)), awd, wd, bd);
                2: do_read(addr, 3'($urandom_range(0, 7)), rd);
                default: do_collide(addr, $urandom(), bd, rd);
            endcase
        end

        for (int n = 0; n < 200 && (bq.size() != 0 || rq.size() != 0); n++) @(posedge aclk);
        check("queue_drain", bq.size() + rq.size(), 0);
        #1;
        for (int i = 0; i < NR; i++)
            check("reg_o", reg_out[i*32 +: 32], RO[i] ? hw[i*32 +: 32] : model[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
